// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//
// Bank of DEPTH registers of WIDTH bits with one synchronous write port and two
// independent read ports (A and B). Each read port has a registered output and
// write-to-read bypass: a read sees the value storage will hold after the same
// edge, so d_a/d_b never lag storage. A disabled port drives zero rather than
// holding its last value, so the outputs can be OR-ed onto a shared operand bus.
//
// Parameters
//   WIDTH     data width of each register
//   DEPTH     number of registers (2..256)
//   ZERO_REG  1: register 0 reads as zero and ignores writes
//   AW        address width, derived from DEPTH
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous active-high; clears storage and both outputs
//   clear      synchronous active-high functional clear of storage
//   we         write enable
//   wr_addr    write address
//   wr_data    write data
//   oe_a       read enable, port A
//   rd_addr_a  read address, port A
//   d_a        registered read data, port A (zero when oe_a was low)
//   oe_b       read enable, port B
//   rd_addr_b  read address, port B
//   d_b        registered read data, port B (zero when oe_b was low)
//
// Edge priority: reset > clear > we.
// -----------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             oe_a,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] d_a,
    input  logic             oe_b,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] d_b
);

    // DEPTH expressed in AW+1 bits so it can be compared against an address
    // without mixing widths. Only matters when DEPTH is not a power of two.
    localparam logic [AW:0] DEPTH_LIMIT = DEPTH[AW:0];

    logic [WIDTH-1:0] regs [DEPTH];

    logic             wr_effective;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;

    // True when addr names a real register that can hold a nonzero value.
    function automatic logic addr_live(input logic [AW-1:0] addr);
        logic live;
        live = ({1'b0, addr} < DEPTH_LIMIT);
        if ((ZERO_REG != 0) && (addr == '0)) begin
            live = 1'b0;
        end
        return live;
    endfunction

    // Value register addr will hold after this edge (reset excluded; reset
    // overrides the outputs directly in the sequential block).
    function automatic logic [WIDTH-1:0] post_update(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] value;
        value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == i[AW-1:0]) begin
                value = regs[i];
            end
        end
        // Bypass: a same-edge write to this address wins over stored data.
        if (wr_effective && (wr_addr == addr)) begin
            value = wr_data;
        end
        if (clear || !addr_live(addr)) begin
            value = '0;
        end
        return value;
    endfunction

    // Writes to the hardwired zero register or past the end of the bank are
    // dropped here so neither storage nor the bypass path ever sees them.
    always_comb begin
        wr_effective = we && addr_live(wr_addr);
    end

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here, unconditionally) so no latch is inferred.
    always_comb begin
        next_a = oe_a ? post_update(rd_addr_a) : '0;
        next_b = oe_b ? post_update(rd_addr_b) : '0;
    end

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of its inputs, independent of statement order.
    // NOTE: the storage array is built from flops and is reset with the outputs;
    // the bank must read zero after reset, so it is not left as uninitialised RAM.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            d_a <= '0;
            d_b <= '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    regs[i] <= '0;
                end
            end else if (wr_effective) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_addr == i[AW-1:0]) begin
                        regs[i] <= wr_data;
                    end
                end
            end
            d_a <= next_a;
            d_b <= next_b;
        end
    end

endmodule
